// File: rtl/comp_serial_ctrl_pkg.sv
// Shared encodings for the bit-serial A<=B comparator: relation codes and FSM states.
// The relation codes are also used by the combinational cell.
package comp_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        REL_EQ = 2'b00,
        REL_GT = 2'b01,
        REL_LT = 2'b10
    } rel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/comp_celda.sv
// Combinational comparator cell, MSB-first: the first differing bit decides the relation.
// Reusable as one stage of the parallel comparator network.
module comp_celda
    import comp_serial_ctrl_pkg::*;
(
    input  logic [1:0] rel_in,
    input  logic       a,
    input  logic       b,
    output logic [1:0] rel_out
);

    always_comb begin
        rel_out = rel_in;
        if (rel_in == REL_EQ) begin
            if (a && !b) begin
                rel_out = REL_GT;
            end else if (!a && b) begin
                rel_out = REL_LT;
            end else begin
                rel_out = REL_EQ;
            end
        end
    end

endmodule

// File: rtl/comp_serial_ctrl.sv
// Bit-serial A<=B comparator: latches A/B on start and feeds one bit per clock to comp_celda.
// Optional COMP_EARLY_EXIT_EN finishes as soon as the first differing bit has been seen.
module comp_serial_ctrl
    import comp_serial_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         Zout,
    output logic [1:0]   dbg_state
);

    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     sa_q, sa_d;
    logic [N-1:0]     sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rel_q, rel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zout_q, zout_d;
    logic [1:0]       rel_next;
    logic             finish;

    comp_celda u_cell (
        .rel_in  (rel_q),
        .a       (sa_q[N-1]),
        .b       (sb_q[N-1]),
        .rel_out (rel_next)
    );

    // A decided relation can never change again, so early exit only skips redundant bits.
`ifdef COMP_EARLY_EXIT_EN
    assign finish = (cnt_q == CNT_LAST) || (rel_next != REL_EQ);
`else
    assign finish = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        zout_d  = zout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    rel_d   = REL_EQ;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rel_d = rel_next;
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (finish) begin
                    zout_d  = (rel_next != REL_GT);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they line up with state_q.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            rel_q   <= REL_EQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zout_q  <= zout_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Zout      = zout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Bench for comp_serial_ctrl (N=3): directed scenarios, randomized operations and a full sweep.
// Expected Zout and RUN length come from plain arithmetic on the operands.
module tb_comp_serial_ctrl;

    localparam int N = 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic         Zout;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];
    logic       last_z;

    comp_serial_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Zout      (Zout),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // RUN length: N normally; with early exit, bits examined up to and including the first difference.
    function automatic int exp_lat(input int a, input int b);
`ifdef COMP_EARLY_EXIT_EN
        int d;
        d = a ^ b;
        if (d == 0) return N;
        return N - ($clog2(d + 1) - 1);
`else
        return N;
`endif
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit mid_start, input string tag);
        int   run_cycles;
        bit   seen;
        logic exp_z;
        @(posedge clk);
        #1;
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(a <= b);
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = N'($urandom);
        B     = N'($urandom);
        run_cycles = 0;
        seen       = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mid_start && c == 0) begin
                start = 1'b1;
                A     = '0;
                B     = '1;
            end
            if (mid_start && c == 1) start = 1'b0;
            if (c == 0) check({tag, "_zout_hold"}, Zout, last_z);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) run_cycles++;
        end
        check({tag, "_done_seen"}, seen, 1);
        exp_z  = exp_q.pop_front();
        last_z = exp_z;
        check({tag, "_zout"}, Zout, exp_z);
        check({tag, "_run_len"}, run_cycles, exp_lat(a, b));
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        if (mid_start) begin
            int extra;
            extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check({tag, "_no_queue"}, extra, 0);
        end
    endtask

    task automatic run_reset_mid(input logic [N-1:0] a, input logic [N-1:0] b);
        int pulses;
        @(posedge clk);
        #1;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("rst_mid_busy1", busy, 1);
        @(negedge clk);
        check("rst_mid_busy2", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_z = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_zout", Zout, 0);
        check("rst_mid_state", dbg_state, 0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst_mid_no_done", pulses, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        last_z = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_zout", Zout, 0);
        check("reset_state", dbg_state, 0);
        rst = 1'b0;

        run_op(3'b101, 3'b011, 1'b0, "t1");
        run_op(3'b011, 3'b101, 1'b0, "t2");
        run_op(3'b110, 3'b110, 1'b0, "t3");
        run_op(3'b101, 3'b011, 1'b1, "t4");

        run_op(3'b000, 3'b111, 1'b0, "t5_pre");
`ifdef COMP_EARLY_EXIT_EN
        run_reset_mid(3'b000, 3'b001);
`else
        run_reset_mid(3'b000, 3'b111);
`endif
        run_op(3'b111, 3'b000, 1'b0, "t5_post");

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(N'($urandom), N'($urandom), ($urandom_range(0, 3) == 0), "rand");
        end

        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << N); b++) begin
                run_op(N'(a), N'(b), 1'b0, $sformatf("sweep_a%0d_b%0d", a, b));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
